fetch_decode: RTL and testbench

- Front-end stage directly upstream of the ALU/execute stage.
- Owns the program counter and issues addresses to a synchronous-read instruction memory.
- Registers each returned 9-bit instruction and decodes it into the 5-bit ALU op, register select, sign-extended immediate and control flags that execute consumes.
- Handles stall, branch redirect with squash, and HALT.

---
 rtl/fetch_decode_pkg.sv | 34 +++
 rtl/fetch_decode_instr_decoder.sv | 40 ++++
 rtl/fetch_decode.sv | 123 ++++++++++++
 tb/tb_fetch_decode.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: opcode constants, class codes and the decoded-instruction
// record shared by the fetch/decode front end and its instruction decoder.
package fetch_decode_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b01110;

  // Class-type instructions carry their class in instr[8:6].
  localparam logic [2:0] CLS_ADDI = 3'b100;
  localparam logic [2:0] CLS_BNE  = 3'b101;
  localparam logic [2:0] CLS_BEZ  = 3'b110;
  localparam logic [2:0] CLS_MV   = 3'b111;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] rsel;
    logic [7:0] imm;
    logic       is_bne;
    logic       is_bez;
    logic       is_mv;
    logic       illegal;
  } dec_instr_t;

  // R-type opcodes execute understands, HALT included.
  function automatic logic r_op_known(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
      5'b01111, OP_HALT: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_instr_decoder.sv
// instr_decoder: purely combinational 9-bit instruction -> dec_instr_t.
// Ports:
//   instr_i  9-bit instruction word
//   dec_o    decoded op, register select, sign-extended imm and flags
module instr_decoder
  import fetch_decode_pkg::*;
(
  input  logic [8:0] instr_i,
  output dec_instr_t dec_o
);

  always_comb begin
    dec_o = '0;
    if (!instr_i[8]) begin
      // R-type: unknown opcodes collapse to an ADD r0 so they retire as a NOP.
      if (r_op_known(instr_i[8:4])) begin
        dec_o.op   = instr_i[8:4];
        dec_o.rsel = instr_i[3:0];
      end else begin
        dec_o.op      = OP_ADD;
        dec_o.illegal = 1'b1;
      end
    end else begin
      dec_o.op  = {instr_i[8:6], 2'b00};
      dec_o.imm = {{2{instr_i[5]}}, instr_i[5:0]};
      case (instr_i[8:6])
        CLS_BNE: dec_o.is_bne = 1'b1;
        CLS_BEZ: dec_o.is_bez = 1'b1;
        CLS_MV: begin
          // MV reuses the immediate field as dst/src register numbers.
          dec_o.is_mv = 1'b1;
          dec_o.rsel  = {1'b0, instr_i[5:3]};
          dec_o.imm   = {5'b0, instr_i[2:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: front end ahead of execute. Owns the PC, drives a
// synchronous-read instruction memory, registers and decodes the returned
// instruction, and handles stall, redirect (squash) and HALT.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   imem_addr / imem_data          fetch address out, instruction back a cycle later
//   stall                          execute busy: hold everything
//   redirect_valid / redirect_pc   taken branch; squashes in-flight fetches
//   dec_*                          decoded instruction presented to execute
//   halted                         HALT decoded, fetch stopped until reset
//   dec_count                      wrapping count of presented instructions
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int          PC_W     = 10,
  parameter int          INSTR_W  = 9,
  parameter int unsigned START_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  output logic [PC_W-1:0]    dec_pc,
  output logic [4:0]         dec_alu_op,
  output logic [3:0]         dec_reg,
  output logic [7:0]         dec_imm,
  output logic               dec_is_bne,
  output logic               dec_is_bez,
  output logic               dec_is_mv,
  output logic               dec_illegal,
  output logic               halted,
  output logic [15:0]        dec_count
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(START_PC);

  logic [PC_W-1:0] pc_q, pc_d, fetch_pc_q, fetch_pc_d, dec_pc_q, dec_pc_d;
  logic            fetch_valid_q, fetch_valid_d, dec_valid_q, dec_valid_d;
  logic            halted_q, halted_d;
  logic [15:0]     dec_count_q, dec_count_d;
  dec_instr_t      dec_q, dec_d, dec_w;
  logic            is_halt_w;

  instr_decoder u_dec (
    .instr_i (imem_data),
    .dec_o   (dec_w)
  );

  // Illegal ops are rewritten to ADD, so op==HALT can only come from HALT.
  assign is_halt_w = (dec_w.op == OP_HALT);

  // During a stall re-issue the in-flight address so imem_data stays put.
  assign imem_addr = (stall && !redirect_valid) ? fetch_pc_q : pc_q;

  always_comb begin
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    dec_valid_d   = dec_valid_q;
    dec_pc_d      = dec_pc_q;
    dec_d         = dec_q;
    halted_d      = halted_q;
    dec_count_d   = dec_count_q;
    if (redirect_valid && !halted_q) begin
      pc_d          = redirect_pc;
      fetch_valid_d = 1'b0;
      dec_valid_d   = 1'b0;
    end else if (halted_q) begin
      fetch_valid_d = 1'b0;
      dec_valid_d   = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_q + PC_W'(1);
      fetch_pc_d    = pc_q;
      fetch_valid_d = 1'b1;
      dec_valid_d   = fetch_valid_q;
      dec_pc_d      = fetch_pc_q;
      dec_d         = dec_w;
      if (fetch_valid_q) begin
        dec_count_d = dec_count_q + 16'd1;
        if (is_halt_w) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RST;
      fetch_pc_q    <= PC_RST;
      fetch_valid_q <= 1'b0;
      dec_valid_q   <= 1'b0;
      dec_pc_q      <= '0;
      dec_q         <= '0;
      halted_q      <= 1'b0;
      dec_count_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      dec_valid_q   <= dec_valid_d;
      dec_pc_q      <= dec_pc_d;
      dec_q         <= dec_d;
      halted_q      <= halted_d;
      dec_count_q   <= dec_count_d;
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_pc      = dec_pc_q;
  assign dec_alu_op  = dec_q.op;
  assign dec_reg     = dec_q.rsel;
  assign dec_imm     = dec_q.imm;
  assign dec_is_bne  = dec_q.is_bne;
  assign dec_is_bez  = dec_q.is_bez;
  assign dec_is_mv   = dec_q.is_mv;
  assign dec_illegal = dec_q.illegal;
  assign halted      = halted_q;
  assign dec_count   = dec_count_q;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed program scenarios plus randomized stall/redirect/
// reset traffic, all compared against an instruction-stream reference model.
// A second PC_W=4 instance runs straight-line code to exercise PC wrap.
module tb_fetch_decode;
  localparam int PC_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0, imem_addr, dec_pc;
  logic [8:0]      imem_data;
  logic            dec_valid, dec_is_bne, dec_is_bez, dec_is_mv, dec_illegal, halted;
  logic [4:0]      dec_alu_op;
  logic [3:0]      dec_reg;
  logic [7:0]      dec_imm;
  logic [15:0]     dec_count;

  logic [8:0] mem [0:1023];
  always @(posedge clk) imem_data <= mem[imem_addr];

  fetch_decode #(.PC_W(PC_W), .INSTR_W(9), .START_PC(0)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_alu_op(dec_alu_op), .dec_reg(dec_reg),
    .dec_imm(dec_imm), .dec_is_bne(dec_is_bne), .dec_is_bez(dec_is_bez),
    .dec_is_mv(dec_is_mv), .dec_illegal(dec_illegal), .halted(halted), .dec_count(dec_count)
  );

  // Narrow-PC instance: never stalled or redirected, memory holds ADD r<addr>.
  logic       zero4 = 1'b0;
  logic [3:0] addr4, dpc4, dreg4, rpc4 = '0;
  logic [8:0] idata4;
  logic       dvalid4, bne4, bez4, mv4, ill4, halted4;
  logic [4:0] op4;
  logic [7:0] imm4;
  logic [15:0] cnt4;
  logic [8:0] mem4 [0:15];
  always @(posedge clk) idata4 <= mem4[addr4];

  fetch_decode #(.PC_W(4), .INSTR_W(9), .START_PC(0)) u_dut4 (
    .clk(clk), .reset(reset), .imem_addr(addr4), .imem_data(idata4),
    .stall(zero4), .redirect_valid(zero4), .redirect_pc(rpc4),
    .dec_valid(dvalid4), .dec_pc(dpc4), .dec_alu_op(op4), .dec_reg(dreg4),
    .dec_imm(imm4), .dec_is_bne(bne4), .dec_is_bez(bez4),
    .dec_is_mv(mv4), .dec_illegal(ill4), .halted(halted4), .dec_count(cnt4)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the encoding rules, using integer arithmetic.
  task automatic ref_dec(input int i, output int op, output int rg, output int imm,
                         output bit bne, output bit bez, output bit mv,
                         output bit ill, output bit halt);
    int cls, v;
    op = 0; rg = 0; imm = 0; bne = 0; bez = 0; mv = 0; ill = 0; halt = 0;
    if (i < 256) begin
      op = i / 16;
      if (op == 14) begin halt = 1; rg = i % 16; end
      else if (op inside {0, 1, 2, 3, 7, 8, 9, 10, 11, 12, 15}) rg = i % 16;
      else begin op = 0; ill = 1; end
    end else begin
      cls = i / 64;
      op  = cls * 4;
      v   = i % 64;
      imm = (v >= 32) ? v + 192 : v;
      bne = (cls == 5);
      bez = (cls == 6);
      mv  = (cls == 7);
      if (mv) begin rg = (i / 8) % 8; imm = i % 8; end
    end
  endtask

  // Stream model: next address to fetch, at most one fetched-but-unpresented
  // address, and the instruction currently presented to execute.
  int m_nxt, m_qpc, m_pc, m_op, m_reg, m_imm, m_cnt;
  bit m_qv, m_valid, m_bne, m_bez, m_mv, m_ill, m_halted, m_known;
  int cyc4 = 0;

  task automatic model_step(input bit rst, input bit stl, input bit rdv, input int tgt);
    bit h;
    if (rst) begin
      m_nxt = 0; m_qv = 0; m_valid = 0; m_pc = 0; m_op = 0; m_reg = 0; m_imm = 0;
      m_bne = 0; m_bez = 0; m_mv = 0; m_ill = 0; m_halted = 0; m_cnt = 0; m_known = 1;
    end else if (rdv && !m_halted) begin
      m_nxt = tgt; m_qv = 0; m_valid = 0;
    end else if (m_halted) begin
      m_qv = 0; m_valid = 0;
    end else if (!stl) begin
      m_valid = m_qv;
      m_known = m_qv;
      if (m_qv) begin
        m_pc = m_qpc;
        ref_dec(int'(mem[m_qpc]), m_op, m_reg, m_imm, m_bne, m_bez, m_mv, m_ill, h);
        if (h) m_halted = 1;
        m_cnt = (m_cnt + 1) % 65536;
      end
      m_qv  = 1;
      m_qpc = m_nxt;
      m_nxt = (m_nxt + 1) % 1024;
    end
  endtask

  task automatic cyc(input bit rst, input bit stl, input bit rdv, input int tgt);
    @(negedge clk);
    reset = rst; stall = stl; redirect_valid = rdv; redirect_pc = PC_W'(tgt);
    #1;
    if (!rst) begin
      if (!stl || rdv) chk("imem_addr", imem_addr, m_nxt);
      else if (m_qv)   chk("imem_addr_hold", imem_addr, m_qpc);
    end
    @(posedge clk);
    model_step(rst, stl, rdv, tgt);
    if (rst) cyc4 = 0; else cyc4++;
    #1;
    chk("dec_valid", dec_valid, m_valid);
    chk("halted", halted, m_halted);
    chk("dec_count", dec_count, m_cnt);
    if (m_known) begin
      chk("dec_pc", dec_pc, m_pc);
      chk("dec_alu_op", dec_alu_op, m_op);
      chk("dec_reg", dec_reg, m_reg);
      chk("dec_imm", dec_imm, m_imm);
      chk("dec_flags", {dec_is_bne, dec_is_bez, dec_is_mv, dec_illegal},
          {m_bne, m_bez, m_mv, m_ill});
    end
    if (cyc4 >= 2) begin
      chk("w4_valid", dvalid4, 1);
      chk("w4_pc", dpc4, (cyc4 - 2) % 16);
      chk("w4_reg", dreg4, (cyc4 - 2) % 16);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem4[i] = 9'(i);
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    mem[0] = 9'h001; mem[1] = 9'h012; mem[2] = 9'h13E; mem[3] = 9'h1DD;
    mem[4] = 9'h023; mem[5] = 9'h034; mem[6] = 9'h045; mem[7] = 9'h056;
    mem[10'h40] = 9'h0C7;

    // Straight-line start, stall at pc 1, redirect while pc 5 is shown.
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_count", dec_count, 0);
    run(1);
    chk("boot_bubble", dec_valid, 0);
    run(1);
    chk("first_pc", dec_pc, 0);
    chk("first_op", dec_alu_op, 5'b00000);
    run(1);
    repeat (3) cyc(0, 1, 0, 0);
    chk("stall_pc", dec_pc, 1);
    chk("stall_op", dec_alu_op, 5'b00001);
    run(1);
    chk("post_stall_pc", dec_pc, 2);
    chk("addi_op", dec_alu_op, 5'b10000);
    chk("addi_imm", dec_imm, 8'hFE);
    run(1);
    chk("mv_op", dec_alu_op, 5'b11100);
    chk("mv_reg", dec_reg, 3);
    chk("mv_imm", dec_imm, 5);
    chk("mv_flag", dec_is_mv, 1);
    chk("count_after_3", dec_count, 4);
    run(2);
    chk("pre_redir_pc", dec_pc, 5);
    cyc(0, 0, 1, 'h40);
    chk("redir_bubble1", dec_valid, 0);
    run(1);
    chk("redir_bubble2", dec_valid, 0);
    run(1);
    chk("redir_target", dec_pc, 'h40);
    chk("redir_target_v", dec_valid, 1);

    // HALT at address 4: shown once, then dead until reset, redirect ignored.
    mem[4] = 9'h0E0;
    cyc(1, 0, 0, 0);
    run(6);
    chk("halt_pc", dec_pc, 4);
    chk("halt_valid", dec_valid, 1);
    chk("halt_flag", halted, 1);
    cyc(0, 0, 1, 'h40);
    chk("halt_squash", dec_valid, 0);
    repeat (3) cyc(0, 0, 1, 'h80);
    run(3);
    chk("halt_stays", halted, 1);
    cyc(1, 0, 0, 0);
    chk("halt_cleared", halted, 0);
    run(2);
    chk("restart_pc", dec_pc, 0);

    // Redirect while HALT is on imem_data squashes it.
    cyc(1, 0, 0, 0);
    run(5);
    chk("pre_squash_pc", dec_pc, 3);
    cyc(0, 0, 1, 'h40);
    chk("halt_squashed", halted, 0);
    run(3);
    chk("squash_target", dec_pc, 'h41);

    // Unknown R opcode decodes as an illegal ADD r0.
    mem[0] = 9'h04A;
    cyc(1, 0, 0, 0);
    run(2);
    chk("illegal_flag", dec_illegal, 1);
    chk("illegal_op", dec_alu_op, 0);
    chk("illegal_reg", dec_reg, 0);
    run(1);
    chk("after_illegal", dec_illegal, 0);
    chk("after_illegal_op", dec_alu_op, 5'b00001);

    // Random code and random stall/redirect/reset traffic.
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 9'($urandom);
      if (mem[i][8:4] == 5'b01110 && ($urandom % 8) != 0) mem[i] = 9'h000;
    end
    cyc(1, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      int tgt;
      tgt = $urandom % 1024;
      if ($urandom % 4 == 0) tgt = 1020 + ($urandom % 4);
      cyc(($urandom % 100) == 0, ($urandom % 4) == 0, ($urandom % 10) == 0, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
